// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game controller.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_SHOW,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam logic [3:0] LED_ALL_ON = 4'b1111;
  localparam int         LEVEL_W    = 5;
  localparam int         IDX_W      = 4;
  localparam int         COLOR_W    = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/genius_ctrl_if.sv
// Player/ROM/LED side signals of the game controller.
interface genius_ctrl_if;
  import genius_pkg::*;

  logic                 start;
  logic [COLOR_W-1:0]   btn;
  logic [IDX_W-1:0]     rom_addr;
  logic [COLOR_W-1:0]   rom_data;
  logic [COLOR_W-1:0]   led;
  logic [LEVEL_W-1:0]   level;
  logic                 busy;
  logic                 win;
  logic                 lose;

  modport master (
    input  start, btn, rom_data,
    output rom_addr, led, level, busy, win, lose
  );

  modport slave (
    output start, btn, rom_data,
    input  rom_addr, led, level, busy, win, lose
  );

endinterface

// File: rtl/genius_timer.sv
// Clearable up-counter with a terminal-count compare against a runtime limit.
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/genius_ctrl.sv
// Simon game sequencer: plays the first `level` ROM colours, then checks the
// player's presses against the same entries, advancing level or ending the game.
module genius_ctrl
  import genius_pkg::*;
#(
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int SEQ_LEN        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  genius_ctrl_if.master bus
);

  localparam int MAX_CYC = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0]   SHOW_TC = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0]   GAP_TC  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TOUT_TC = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(SEQ_LEN);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [IDX_W-1:0]     rom_addr_q;
  logic [COLOR_W-1:0]   led;
  logic                 busy, win, lose;
  logic                 tmr_clr, tmr_en, tmr_tc, press_clr;
  logic [TMR_W-1:0]     tmr_term;
  logic                 last_idx;

  assign last_idx = ({1'b0, idx_q} == (level_q - 1'b1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    level_d   = level_q;
    press_clr = 1'b0;
    led       = '0;
    busy      = 1'b0;
    win       = 1'b0;
    lose      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          level_d = LEVEL_W'(1);
          idx_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (tmr_tc) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        busy = 1'b1;
        led  = bus.rom_data;
        if (tmr_tc) begin
          if (!last_idx) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_GAP;
          end else begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
          end
        end
      end
      ST_WAIT_IN: begin
        led = bus.btn;
        // A press in the timeout cycle still counts, so it is checked first.
        if (bus.btn != '0) begin
          if (bus.btn != bus.rom_data) begin
            state_d = ST_LOSE;
          end else if (!last_idx) begin
            idx_d     = idx_q + 1'b1;
            press_clr = 1'b1;
          end else if (level_q < LVL_MAX) begin
            level_d = level_q + 1'b1;
            idx_d   = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_WIN;
          end
        end else if (tmr_tc) begin
          state_d = ST_LOSE;
        end
      end
      ST_WIN, ST_LOSE: begin
        win  = (state_q == ST_WIN);
        lose = (state_q == ST_LOSE);
        led  = (state_q == ST_WIN) ? LED_ALL_ON : bus.rom_data;
        if (bus.start) begin
          level_d = LEVEL_W'(1);
          idx_d   = '0;
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_term = TOUT_TC;
    case (state_q)
      ST_GAP:  tmr_term = GAP_TC;
      ST_SHOW: tmr_term = SHOW_TC;
      default: tmr_term = TOUT_TC;
    endcase
  end

  assign tmr_en  = (state_q == ST_GAP) || (state_q == ST_SHOW) || (state_q == ST_WAIT_IN);
  assign tmr_clr = press_clr || (state_d != state_q);

  genius_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

  // rom_addr is registered from next idx so the ROM always shows entry idx_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      level_q    <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      rom_addr_q <= idx_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.level    = level_q;
  assign bus.led      = led;
  assign bus.busy     = busy;
  assign bus.win      = win;
  assign bus.lose     = lose;

endmodule
